// File: rtl/alpha_unblend.sv
// Recovers straight ARGB4444 colour from a premultiplied 8-bit RGB pixel by a
// 4-step per-channel binary search against the forward premultiply; optional out_exact via ALPHA_UNBLEND_EXACT_EN.
module alpha_unblend (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_a,
  output logic [3:0] out_r,
  output logic [3:0] out_g,
  output logic [3:0] out_b,
`ifdef ALPHA_UNBLEND_EXACT_EN
  output logic       out_exact,
`endif
  output logic [1:0] state_dbg
);

  // Handshakes: a transfer happens on a clk edge where valid && ready; valid
  // never waits on ready, and out_* hold stable while out_valid && !out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_nxt;
  logic [3:0]        a_q;
  logic [2:0][7:0]   p_q;
  logic [2:0][3:0]   cand_q, cand_nxt, trial;
  logic [1:0]        bit_q;
  logic [3:0]        bit_mask;
  logic              accept;

  function automatic logic [7:0] fwd(input logic [3:0] c, input logic [3:0] a);
    logic [7:0] x;
    logic [7:0] s;
    x = {c, c};
    s = 8'd0;
    for (int i = 0; i < 4; i++)
      if (a[i]) s = s + (x >> (4 - i));
    return s;
  endfunction

  assign state_dbg = state_q;
  assign accept    = (state_q == IDLE) && in_valid && in_ready;
  assign bit_mask  = 4'b0001 << bit_q;

  always_comb begin
    trial    = '0;
    cand_nxt = cand_q;
    for (int i = 0; i < 3; i++) begin
      trial[i]    = cand_q[i] | bit_mask;
      cand_nxt[i] = (fwd(trial[i], a_q) <= p_q[i]) ? trial[i] : cand_q[i];
    end
  end

`ifdef ALPHA_UNBLEND_EXACT_EN
  logic exact_nxt;
  always_comb begin
    exact_nxt = (a_q != 4'd0);
    for (int i = 0; i < 3; i++)
      if (fwd(cand_nxt[i], a_q) != p_q[i]) exact_nxt = 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH:  if (bit_q == 2'd0) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // in_ready/out_valid are registered copies of the next state, so in_ready
  // first rises one edge after reset and never coincides with a release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      p_q       <= '0;
      cand_q    <= '0;
      bit_q     <= '0;
      out_a     <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
`ifdef ALPHA_UNBLEND_EXACT_EN
      out_exact <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        a_q    <= in_a;
        p_q    <= {in_b, in_g, in_r};
        cand_q <= '0;
        bit_q  <= 2'd3;
      end
      if (state_q == SEARCH) begin
        cand_q <= cand_nxt;
        bit_q  <= bit_q - 2'd1;
        if (bit_q == 2'd0) begin
          out_a <= a_q;
          out_r <= (a_q == 4'd0) ? 4'd0 : cand_nxt[0];
          out_g <= (a_q == 4'd0) ? 4'd0 : cand_nxt[1];
          out_b <= (a_q == 4'd0) ? 4'd0 : cand_nxt[2];
`ifdef ALPHA_UNBLEND_EXACT_EN
          out_exact <= exact_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alpha_unblend.sv
// Directed bench for alpha_unblend: vector table, backpressure, mid-search reset
// and an exhaustive fwd round trip with random out_ready.
module tb_alpha_unblend;

  logic       clk, reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_a, out_a, out_r, out_g, out_b;
  logic [7:0] in_r, in_g, in_b;
  logic [1:0] state_dbg;
  logic       exact_act;

`ifdef ALPHA_UNBLEND_EXACT_EN
  logic out_exact;
  assign exact_act = out_exact;
  localparam bit HAS_EXACT = 1'b1;
`else
  assign exact_act = 1'b0;
  localparam bit HAS_EXACT = 1'b0;
`endif

  alpha_unblend dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_r(out_r), .out_g(out_g), .out_b(out_b),
`ifdef ALPHA_UNBLEND_EXACT_EN
    .out_exact(out_exact),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] a;
    logic [7:0] r, g, b;
    logic [3:0] er, eg, eb;
    logic       ex;
  } vec_t;

  vec_t        vecs[9];
  logic [16:0] exp_q[$];
  int          n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] pack_exp(input logic [3:0] a, input logic [3:0] r,
                                           input logic [3:0] g, input logic [3:0] b,
                                           input logic ex);
    return {a, r, g, b, (HAS_EXACT ? ex : 1'b0)};
  endfunction

  function automatic logic [16:0] act_word();
    return {out_a, out_r, out_g, out_b, exact_act};
  endfunction

  function automatic logic [7:0] ref_fwd(input int c, input int a);
    int x, s;
    x = 17 * c;
    s = 0;
    for (int i = 0; i < 4; i++)
      if (((a >> i) & 1) != 0) s = s + (x >> (4 - i));
    return 8'(s);
  endfunction

  // driver tasks
  task automatic drive_pixel(input logic [3:0] a, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_a = a; in_r = r; in_g = g; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit rnd, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end while (!out_valid && lat < 20);
    chk("latency", lat, 4);
  endtask

  function automatic logic [16:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return '1;
  endfunction

  task automatic collect(input bit rnd);
    int lat;
    logic [16:0] e;
    bit rdy;
    wait_valid(rnd, lat);
    chk("queue_size", exp_q.size(), 1);
    e = pop_exp();
    chk("result", act_word(), e);
    for (int k = 0; k < 40; k++) begin
      rdy = rnd ? ((k == 39) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
      out_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
        break;
      end else begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", act_word(), e);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [16:0] e;
    logic [7:0] p;

    n_vec = 0; n_err = 0;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_r = '0; in_g = '0; in_b = '0;

    vecs[0] = '{4'hF, 8'd236, 8'd236, 8'd236, 4'hF, 4'hF, 4'hF, 1'b1};
    vecs[1] = '{4'h8, 8'd68,  8'd25,  8'd30,  4'h8, 4'h3, 4'h3, 1'b0};
    vecs[2] = '{4'h0, 8'hFF,  8'hFF,  8'hFF,  4'h0, 4'h0, 4'h0, 1'b0};
    vecs[3] = '{4'hF, 8'd0,   8'd1,   8'd255, 4'h0, 4'h0, 4'hF, 1'b0};
    vecs[4] = '{4'h1, 8'd15,  8'd16,  8'd14,  4'hF, 4'hF, 4'hE, 1'b0};
    vecs[5] = '{4'h4, 8'd21,  8'd20,  8'd63,  4'h5, 4'h4, 4'hF, 1'b0};
    vecs[6] = '{4'h4, 8'd21,  8'd17,  8'd63,  4'h5, 4'h4, 4'hF, 1'b1};
    vecs[7] = '{4'hA, 8'd106, 8'd115, 8'd116, 4'hA, 4'hA, 4'hB, 1'b0};
    vecs[8] = '{4'h3, 8'd0,   8'd0,   8'd0,   4'h0, 4'h0, 4'h0, 1'b1};

    // reset values
    #3 reset_n = 1'b0;
    #1;
    chk("rst_state", state_dbg, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", act_word(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_release_in_ready", in_ready, 0);
    @(negedge clk);
    chk("first_edge_in_ready", in_ready, 1);

    // vector table
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(pack_exp(vecs[i].a, vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ex));
      drive_pixel(vecs[i].a, vecs[i].r, vecs[i].g, vecs[i].b);
      collect(1'b0);
    end

    // backpressure: hold 10 clocks, stray in_valid ignored
    exp_q.push_back(pack_exp(4'h8, 4'h8, 4'h3, 4'h3, 1'b0));
    drive_pixel(4'h8, 8'd68, 8'd25, 8'd30);
    out_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    chk("bp_latency", lat, 4);
    chk("bp_queue_size", exp_q.size(), 1);
    e = pop_exp();
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; in_a = 4'hF; in_r = 8'd236; in_g = 8'd236; in_b = 8'd236;
      end
      if (k == 6) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", act_word(), e);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_state", state_dbg, 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    exp_q.push_back(pack_exp(4'h1, 4'hF, 4'hF, 4'hE, 1'b0));
    drive_pixel(4'h1, 8'd15, 8'd16, 8'd14);
    collect(1'b0);

    // reset mid-search at E2
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'hF; in_r = 8'd236; in_g = 8'd236; in_b = 8'd236;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_outputs", act_word(), 0);
    chk("mid_rst_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_release_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_first_edge_ready", in_ready, 1);
    exp_q.push_back(pack_exp(4'h1, 4'h6, 4'h0, 4'h0, 1'b1));
    drive_pixel(4'h1, 8'd6, 8'd0, 8'd0);
    collect(1'b0);

    // exhaustive round trip, random out_ready
    for (int a = 1; a < 16; a++) begin
      for (int c = 0; c < 16; c++) begin
        p = ref_fwd(c, a);
        exp_q.push_back(pack_exp(4'(a), 4'(c), 4'(c), 4'(c), 1'b1));
        drive_pixel(4'(a), p, p, p);
        collect(1'b1);
      end
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
